spi_rx_arbiter: RTL and testbench
=================================

SPI_RX_ARBITER -- requirements
Module: spi_rx_arbiter

Interface
REQ-001 Parameter DATA, default 8: FIFO word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16: depth of the shared RX FIFO.
REQ-003 Parameter BURST_MAX, default 16: largest burst a requester may ask for.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port rdata  input  DATA: FIFO read data, valid the cycle after rd.
REQ-007 Port rd  output  1: FIFO read strobe.
REQ-008 Port usedw  input  $clog2(FIFO_DEPTH): FIFO fill level; 0 means empty; updates one cycle after rd.
REQ-009 Port req  input  2: per-requester burst request, level.
REQ-010 Port len0, len1  input  $clog2(BURST_MAX+1) each: burst length, sampled at grant.
REQ-011 Port gnt  output  2: one-hot grant, held for the whole burst.
REQ-012 Port dout  output  DATA: equals rdata, combinational pass-through.
REQ-013 Port dvalid  output  1: dout valid for the granted requester; registered copy of rd.
REQ-014 Port done  output  1: one-cycle pulse at burst end.
REQ-015 Port busy  output  1: high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, BURST, DRAIN, FIN; the state encoding is a typedef enum.
REQ-017 IDLE: if any req bit is high, the block selects a winner, latches its len into remaining, sets gnt, and enters BURST on the next edge.
REQ-018 Arbitration is 2-way round-robin via a last pointer.
  - Both requests high: the requester not equal to last wins.
  - Single request: that requester wins.
  - last updates on every grant.
REQ-019 BURST: rd = (remaining > 0) && (usedw > rd_q), where rd_q is rd delayed one cycle; this prevents over-reading a FIFO whose usedw lags rd by one cycle.
REQ-020 Each cycle rd=1, remaining decrements by 1; remaining never underflows.
REQ-021 BURST->DRAIN when remaining reaches 0 through a read; BURST->FIN directly when the latched len is 0, with zero reads issued.
REQ-022 DRAIN lasts exactly one cycle, so the final dvalid is delivered; then the FSM enters FIN.
REQ-023 FIN: done=1 for one cycle, gnt clears to 0, next state is IDLE. A new grant is possible at the earliest two cycles after done.
REQ-024 Read latency is 1: dvalid is high exactly one cycle after each rd. The number of dvalid pulses per burst equals the latched len.
REQ-025 FIFO empty (usedw=0) during BURST: rd=0 and the block waits indefinitely, with gnt held.
REQ-026 Requester behaviour during a burst:
  - Deasserting req mid-burst does not abort the burst.
  - Changes to len after grant are ignored.
  - req held high across FIN is re-arbitrated in IDLE.
REQ-027 rd is never asserted outside BURST; gnt is always one-hot or zero.

Reset
REQ-028 rst low forces state=IDLE, rd=0, gnt=0, dvalid=0, done=0, busy=0, remaining=0, rd_q=0, last=1 (requester 0 wins first); all take effect immediately, without waiting for clk.
REQ-029 Reset asserted mid-burst abandons the burst without a done pulse. FIFO contents are the producer's concern.

Structure
REQ-030 Package spi_pkg holds the state typedef enum (IDLE, BURST, DRAIN, FIN) and the constant NUM_REQ=2.
REQ-031 Sub-module spi_rr_arbiter implements the 2-way round-robin.
  - Inputs: req, last, en.
  - Outputs: one-hot winner.
  - Purely combinational; the last register stays in the parent.
REQ-032 Width of remaining is $clog2(BURST_MAX+1).

Verification
REQ-033 Single request, data ready: FIFO preloaded with 0x31..0x34, req=01, len0=4.
  - Expect gnt=01 and 4 rd cycles back-to-back.
  - Expect dvalid with dout 0x31,0x32,0x33,0x34.
  - Expect one done pulse, then gnt=00.
REQ-034 Contention: req=11 from reset, len0=2, len1=3.
  - Expect requester 0 served first (2 words), then requester 1 (3 words).
  - With req held at 11, a third grant goes to requester 0.
REQ-035 Starved FIFO: len1=5 with only 2 words present.
  - Expect 2 reads, then rd=0 with gnt=10 held.
  - Push 3 more words; expect 3 more reads and done after the fifth dvalid.
REQ-036 usedw lag: usedw=1, len0=3. Expect exactly one rd, never two in consecutive cycles while usedw still reads 1.
REQ-037 Zero-length request: len0=0. Expect no rd and done one cycle after BURST entry.
REQ-038 Reset mid-burst: assert rst after 2 of 4 reads. Expect rd, gnt, dvalid, busy at 0 asynchronously, no done pulse, and the next burst starting with requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI RX burst arbiter: FSM state encoding and requester count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin pick: on contention the requester that did not win last time wins.
// Latency: purely combinational; the last-winner register lives in the parent.
// Backpressure: none; win is all-zero when en is low or nobody requests.
module spi_rr_arbiter
  import spi_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  input  logic               en,
  output logic [NUM_REQ-1:0] win
);

  // One-hot winner; ties broken against the previous winner.
  always_comb begin
    win = '0;
    if (en) begin
      case (req)
        2'b01:   win = 2'b01;
        2'b10:   win = 2'b10;
        2'b11:   win = last ? 2'b01 : 2'b10;
        default: win = '0;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_arbiter.sv
// Grants bursts of reads from a shared RX FIFO to one of two requesters, round-robin.
// Latency: grant one cycle after request in IDLE; dvalid one cycle after each rd.
// Backpressure: rd stalls while the lagging usedw shows no unread word; gnt is held meanwhile.
module spi_rx_arbiter
  import spi_pkg::*;
#(
  parameter int DATA       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_MAX  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA-1:0]                  rdata,
  output logic                             rd,
  input  logic [$clog2(FIFO_DEPTH)-1:0]    usedw,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [$clog2(BURST_MAX+1)-1:0]   len0,
  input  logic [$clog2(BURST_MAX+1)-1:0]   len1,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [DATA-1:0]                  dout,
  output logic                             dvalid,
  output logic                             done,
  output logic                             busy
);

  localparam int UW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(BURST_MAX+1);

  state_e             state_q, state_d;
  logic [LW-1:0]      remaining_q, remaining_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               rd_q;
  logic [NUM_REQ-1:0] win;

  spi_rr_arbiter u_rr (
    .req  (req),
    .last (last_q),
    .en   (state_q == IDLE),
    .win  (win)
  );

  // Next-state, grant capture and read-strobe generation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rd          = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = win;
          last_d      = win[1];
          remaining_d = win[1] ? len1 : len0;
          state_d     = BURST;
        end
      end
      BURST: begin
        // usedw lags rd by a cycle, so a read issued last cycle is discounted here.
        rd = (remaining_q != '0) && (usedw > UW'(rd_q));
        if (remaining_q == '0) begin
          state_d = FIN;
        end else if (rd) begin
          remaining_d = remaining_q - LW'(1);
          if (remaining_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Lets the dvalid of the last read leave before done.
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; requester 0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gnt_q       <= '0;
      last_q      <= 1'b1;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rd_q        <= rd;
    end
  end

  assign gnt    = gnt_q;
  assign dvalid = rd_q;
  assign dout   = rdata;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_spi_rx_arbiter.sv
// Self-checking bench for spi_rx_arbiter with a lagging-usedw FIFO model and a burst scoreboard.
// Latency: n/a.
// Backpressure: FIFO fill is throttled randomly to exercise read stalls.
module tb_spi_rx_arbiter;
  import spi_pkg::*;

  localparam int DATA       = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BURST_MAX  = 16;
  localparam int UW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(BURST_MAX+1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DATA-1:0] rdata_r;
  logic rd;
  logic [UW-1:0] usedw_r;
  logic [1:0] req;
  logic [LW-1:0] len0, len1;
  logic [1:0] gnt;
  logic [DATA-1:0] dout;
  logic dvalid, done, busy;

  always #5 clk = ~clk;

  spi_rx_arbiter #(.DATA(DATA), .FIFO_DEPTH(FIFO_DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst), .rdata(rdata_r), .rd(rd), .usedw(usedw_r),
    .req(req), .len0(len0), .len1(len1), .gnt(gnt), .dout(dout),
    .dvalid(dvalid), .done(done), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // FIFO model: pop on rd, rdata one cycle later, usedw shows the pre-pop level (one-cycle lag).
  logic [DATA-1:0] fifo_q[$];
  logic [DATA-1:0] refq[$];
  logic rd_s = 1'b0;

  always @(negedge clk) rd_s <= rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q.delete();
      usedw_r <= '0;
      rdata_r <= '0;
    end else begin
      usedw_r <= UW'(fifo_q.size());
      if (rd_s) begin
        if (fifo_q.size() > 0) rdata_r <= fifo_q.pop_front();
        else rdata_r <= 'x;
      end
    end
  end

  task automatic push(input logic [7:0] v);
    if (fifo_q.size() < 14) begin
      fifo_q.push_back(v);
      refq.push_back(v);
    end
  endtask

  // Scoreboard: predicts each grant from round-robin rules and checks burst contents.
  int grant_cnt = 0;
  int done_cnt = 0;
  int rdn = 0;
  int cnt = 0;
  int cur_len = 0;
  int pend_len = 0;
  logic [1:0] cur_gnt = '0;
  logic [1:0] pend_gnt = '0;
  logic [1:0] gnt_log[$];
  logic pend = 1'b0, in_burst = 1'b0, post_done = 1'b0, prev_rd = 1'b0;
  logic model_last = 1'b1;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      refq.delete();
      in_burst = 1'b0;
      pend = 1'b0;
      post_done = 1'b0;
      prev_rd = 1'b0;
      model_last = 1'b1;
    end else begin
      if (pend) begin
        check("grant", 32'(gnt), 32'(pend_gnt));
        model_last = pend_gnt[1];
        cur_gnt = pend_gnt;
        cur_len = pend_len;
        cnt = 0;
        rdn = 0;
        in_burst = 1'b1;
        grant_cnt++;
        gnt_log.push_back(gnt);
        pend = 1'b0;
      end else if (post_done) begin
        check("gnt_clear", 32'(gnt), 32'd0);
      end
      post_done = 1'b0;
      if (in_burst) check("gnt_hold", 32'(gnt), 32'(cur_gnt));
      if (rd) begin
        check("rd_in_burst", 32'(in_burst), 32'd1);
        check("rd_occupancy", 32'(fifo_q.size() > 0), 32'd1);
        if (prev_rd) check("rd_lag", 32'(usedw_r > 1), 32'd1);
        rdn++;
      end
      prev_rd = rd;
      if (dvalid) begin
        if (refq.size() == 0) check("dvalid_spurious", 32'd1, 32'd0);
        else check("dout", 32'(dout), 32'(refq.pop_front()));
        cnt++;
      end
      if (done) begin
        check("done_in_burst", 32'(in_burst), 32'd1);
        check("dvalid_count", 32'(cnt), 32'(cur_len));
        in_burst = 1'b0;
        done_cnt++;
        post_done = 1'b1;
      end
      if (!busy && req != 2'b00) begin
        pend = 1'b1;
        case (req)
          2'b01:   pend_gnt = 2'b01;
          2'b10:   pend_gnt = 2'b10;
          default: pend_gnt = model_last ? 2'b01 : 2'b10;
        endcase
        pend_len = pend_gnt[1] ? int'(len1) : int'(len0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int k = 0;
    while (grant_cnt < target && k < budget) begin tick(); k++; end
    check("grant_timeout", 32'(grant_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin tick(); k++; end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int g, d, k;
    req = 2'b00; len0 = '0; len1 = '0;
    repeat (3) tick();
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    // Single requester, data already waiting: four back-to-back reads.
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
    repeat (2) tick();
    len0 = 5'd4; req = 2'b01;
    d = done_cnt;
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_rd_b2b", 32'(rd), 32'd1);
      check("t1_gnt", 32'(gnt), 32'd1);
    end
    @(negedge clk);
    check("t1_rd_end", 32'(rd), 32'd0);
    wait_done(d + 1, 20);
    check("t1_gnt_after", 32'(gnt), 32'd0);

    // Contention from reset: 0, then 1, then 0 again.
    do_reset();
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    repeat (2) tick();
    g = grant_cnt; d = done_cnt;
    len0 = 5'd2; len1 = 5'd3; req = 2'b11;
    wait_grants(g + 3, 80);
    req = 2'b00;
    wait_done(d + 3, 40);
    if (gnt_log.size() >= g + 3) begin
      check("t2_first", 32'(gnt_log[g]), 32'd1);
      check("t2_second", 32'(gnt_log[g+1]), 32'd2);
      check("t2_third", 32'(gnt_log[g+2]), 32'd1);
    end else begin
      check("t2_grant_log", 32'(gnt_log.size()), 32'(g + 3));
    end

    // Starved FIFO: five requested, two present.
    push(8'h50); push(8'h51);
    repeat (2) tick();
    g = grant_cnt; d = done_cnt;
    len1 = 5'd5; req = 2'b10;
    wait_grants(g + 1, 10);
    req = 2'b00;
    repeat (8) tick();
    check("t3_reads", 32'(rdn), 32'd2);
    check("t3_gnt_held", 32'(gnt), 32'd2);
    check("t3_rd_idle", 32'(rd), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_done", 32'(done_cnt), 32'(d));
    push(8'h52); push(8'h53); push(8'h54);
    wait_done(d + 1, 30);

    // usedw lag: one word, length three.
    push(8'h60);
    repeat (2) tick();
    g = grant_cnt; d = done_cnt;
    len0 = 5'd3; req = 2'b01;
    wait_grants(g + 1, 10);
    req = 2'b00;
    repeat (6) tick();
    check("t4_single_rd", 32'(rdn), 32'd1);
    push(8'h61); push(8'h62);
    wait_done(d + 1, 30);

    // Zero-length burst.
    len0 = 5'd0; req = 2'b01;
    @(negedge clk);
    tick();
    req = 2'b00;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_rd", 32'(rd), 32'd0);
    check("t5_no_done_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_rd_fin", 32'(rd), 32'd0);
    tick();

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    repeat (2) tick();
    g = grant_cnt;
    len0 = 5'd4; req = 2'b01;
    wait_grants(g + 1, 10);
    req = 2'b00;
    d = done_cnt;
    k = 0;
    while (rdn < 2 && k < 20) begin @(negedge clk); #1; k++; end
    check("t6_two_reads", 32'(rdn), 32'd2);
    #1 rst = 1'b0;
    #1;
    check("t6_rd", 32'(rd), 32'd0);
    check("t6_gnt", 32'(gnt), 32'd0);
    check("t6_dvalid", 32'(dvalid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst = 1'b1;
    check("t6_no_done", 32'(done_cnt), 32'(d));
    push(8'h7a); push(8'h7b);
    repeat (2) tick();
    g = grant_cnt; d = done_cnt;
    len0 = 5'd2; len1 = 5'd2; req = 2'b11;
    wait_grants(g + 1, 10);
    req = 2'b00;
    if (gnt_log.size() > g) check("t6_next_req0", 32'(gnt_log[g]), 32'd1);
    else check("t6_next_grant", 32'(gnt_log.size()), 32'(g + 1));
    wait_done(d + 1, 30);

    // Random traffic: requests, lengths and FIFO fill all vary every cycle.
    for (int i = 0; i < 600; i++) begin
      req  = 2'($urandom_range(0, 3));
      len0 = LW'($urandom_range(0, BURST_MAX));
      len1 = LW'($urandom_range(0, BURST_MAX));
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      tick();
    end
    req = 2'b00;
    k = 0;
    while ((busy || in_burst || pend) && k < 500) begin
      push(8'($urandom));
      tick();
      k++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("random_grants", 32'(grant_cnt > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
